// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: LSB-first square-and-multiply modular exponentiation sequencer.
// Ports: i_clk/i_rst_n (async active-low reset), i_start with operands i_a/i_d/i_n,
// result o_a_pow_d with o_finished pulse and o_busy; prep unit handshake
// (o_prep_start, o_prep_a, o_prep_n, i_prep_result, i_prep_finish); shared Montgomery
// unit handshake (o_mont_start, o_mont_a, o_mont_b, o_mont_n, i_mont_result, i_mont_finish).
module rsa_exp_ctrl #(
  parameter int W     = 256,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_d,
  input  logic [W-1:0]     i_n,
  output logic [W-1:0]     o_a_pow_d,
  output logic             o_finished,
  output logic             o_busy,
  output logic             o_prep_start,
  output logic [W-1:0]     o_prep_a,
  output logic [W-1:0]     o_prep_n,
  input  logic [W-1:0]     i_prep_result,
  input  logic             i_prep_finish,
  output logic             o_mont_start,
  output logic [W-1:0]     o_mont_a,
  output logic [W-1:0]     o_mont_b,
  output logic [W-1:0]     o_mont_n,
  input  logic [W-1:0]     i_mont_result,
  input  logic             i_mont_finish
);
  typedef enum logic [2:0] {IDLE, PREP, MULT, SQR, DONE} state_t;
  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_t, r_m, r_d, r_n, r_a, r_mont_a, r_mont_b, w_t_nxt, w_m_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_first, w_mont_ok, w_prep_ok;
  // r_first marks the first cycle of a state: start pulses fire there, and a finish
  // seen on that same cycle cannot belong to the request being issued.
  assign w_mont_ok = i_mont_finish & ~r_first;
  assign w_prep_ok = i_prep_finish & ~r_first;
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_m_nxt     = r_m;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (i_start) begin
        w_state_nxt = PREP;
        w_cnt_nxt   = '0;
      end
      PREP: if (w_prep_ok) begin
        w_state_nxt = MULT;
        w_t_nxt     = i_prep_result;
        w_m_nxt     = W'(1);
      end
      MULT: if (!r_d[r_cnt]) w_state_nxt = SQR;
      else if (w_mont_ok) begin
        w_state_nxt = SQR;
        w_m_nxt     = i_mont_result;
      end
      SQR: if (w_mont_ok) begin
        w_t_nxt     = i_mont_result;
        w_state_nxt = (r_cnt == CNT_W'(W-1)) ? DONE : MULT;
        w_cnt_nxt   = (r_cnt == CNT_W'(W-1)) ? r_cnt : r_cnt + 1'b1;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_t      <= '0;
      r_m      <= '0;
      r_d      <= '0;
      r_n      <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_mont_a <= '0;
      r_mont_b <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_t      <= w_t_nxt;
      r_m      <= w_m_nxt;
      r_cnt    <= w_cnt_nxt;
      r_first  <= w_state_nxt != r_state;
      // t and m only move on the transition out of a waiting state, so these stay
      // stable for the whole Montgomery operation.
      r_mont_a <= (w_state_nxt == MULT) ? w_m_nxt : w_t_nxt;
      r_mont_b <= w_t_nxt;
      if (r_state == IDLE && i_start) begin
        r_a <= i_a;
        r_d <= i_d;
        r_n <= i_n;
      end
    end
  end
  assign o_busy       = r_state != IDLE;
  assign o_finished   = r_state == DONE;
  assign o_prep_start = r_first && r_state == PREP;
  assign o_mont_start = r_first && (r_state == SQR || (r_state == MULT && r_d[r_cnt]));
  assign o_a_pow_d    = r_m;
  assign o_prep_a     = r_a;
  assign o_prep_n     = r_n;
  assign o_mont_a     = r_mont_a;
  assign o_mont_b     = r_mont_b;
  assign o_mont_n     = r_n;
endmodule
